video_capture: RTL and testbench

VIDEO_CAPTURE -- requirements
Module: video_capture

---
 rtl/video_capture_if.sv | 21 ++
 rtl/video_capture.sv | 100 ++++++++++
 tb/tb_video_capture.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_capture_if.sv
// video_capture_if: video input, capture control and frame-buffer write bundle.
interface video_capture_if;
  logic        vid_vs;
  logic        vid_de;
  logic [23:0] vid_rgb;
  logic        capture_req;
  logic        ram_wr_en;
  logic [15:0] ram_wr_addr;
  logic [23:0] ram_wr_data;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  modport master(
    output vid_vs, vid_de, vid_rgb, capture_req,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, busy, frame_done, frame_err
  );
  modport slave(
    input  vid_vs, vid_de, vid_rgb, capture_req,
    output ram_wr_en, ram_wr_addr, ram_wr_data, busy, frame_done, frame_err
  );
endinterface

// File: rtl/video_capture.sv
// video_capture: grabs a window of a VS/DE video stream into a frame buffer.
// Define VIDEO_CAPTURE_GRAY_EN to store luma {Y,Y,Y} instead of raw RGB.
module video_capture #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int X_OFS = 0,
  parameter int Y_OFS = 0,
  parameter int CONT  = 0
) (
  input logic clk,
  input logic rst,
  video_capture_if.slave vif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_VS = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
  localparam logic [16:0] X_LO = 17'(X_OFS), X_HI = 17'(X_OFS + IMG_W);
  localparam logic [16:0] Y_LO = 17'(Y_OFS), Y_HI = 17'(Y_OFS + IMG_H);
  localparam logic [15:0] LAST = 16'(IMG_W * IMG_H - 1);
  logic        vs1, vs1_d, de1, de1_d;
  logic [23:0] rgb1, pix, wr_data;
  logic [15:0] cx, cy, row, addr, wa, wr_addr;
  logic [1:0]  st;
  logic        vs_rise, de_fall, in_win, wr, wr_en, done, err;
`ifdef VIDEO_CAPTURE_GRAY_EN
  logic [7:0] luma;
  assign luma = 8'((16'd77 * {8'd0, rgb1[23:16]} + 16'd150 * {8'd0, rgb1[15:8]}
                  + 16'd29 * {8'd0, rgb1[7:0]}) >> 8);
  assign pix = {3{luma}};
`else
  assign pix = rgb1;
`endif
  // a pixel arriving with the frame-start edge already belongs to row 0
  always_comb begin
    vs_rise = vs1 & ~vs1_d;
    de_fall = de1_d & ~de1;
    row     = vs_rise ? '0 : cy;
    in_win  = de1 && {1'b0, cx} >= X_LO && {1'b0, cx} < X_HI
                  && {1'b0, row} >= Y_LO && {1'b0, row} < Y_HI;
    wr      = st == CAPTURE && in_win;
    wa      = vs_rise ? '0 : addr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs1   <= 1'b0;
      vs1_d <= 1'b0;
      de1   <= 1'b0;
      de1_d <= 1'b0;
      rgb1  <= '0;
      cx    <= '0;
      cy    <= '0;
    end else begin
      vs1   <= vif.vid_vs;
      vs1_d <= vs1;
      de1   <= vif.vid_de;
      de1_d <= de1;
      rgb1  <= vif.vid_rgb;
      cx    <= de1 ? cx + 16'd1 : '0;
      cy    <= vs_rise ? '0 : de_fall ? cy + 16'd1 : cy;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      addr    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_en <= wr;
      done  <= st == DONE;
      if (wr) begin
        wr_addr <= wa;
        wr_data <= pix;
      end
      case (st)
        IDLE: if (vif.capture_req) begin
          st  <= WAIT_VS;
          err <= 1'b0;
        end
        WAIT_VS: if (vs_rise) begin
          st   <= CAPTURE;
          addr <= '0;
        end
        CAPTURE: begin
          if (vs_rise) err <= 1'b1;
          addr <= wr ? wa + 16'd1 : wa;
          if (wr && wa == LAST) st <= DONE;
        end
        default: st <= CONT != 0 ? WAIT_VS : IDLE;
      endcase
    end
  end
  assign vif.ram_wr_en   = wr_en;
  assign vif.ram_wr_addr = wr_addr;
  assign vif.ram_wr_data = wr_data;
  assign vif.busy        = st != IDLE;
  assign vif.frame_done  = done;
  assign vif.frame_err   = err;
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed frames into a single-shot and a continuous capture
// instance, checked every cycle against a position-based model plus literal pins.
module tb_video_capture;
  localparam int W = 4, H = 2, XO = 1, YO = 1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        vs, de, req0, req1;
  logic [23:0] rgb;
  int          px, py;
  logic [23:0] pix[3][6];
  video_capture_if vi0 ();
  video_capture_if vi1 ();
  assign vi0.vid_vs = vs;
  assign vi0.vid_de = de;
  assign vi0.vid_rgb = rgb;
  assign vi0.capture_req = req0;
  assign vi1.vid_vs = vs;
  assign vi1.vid_de = de;
  assign vi1.vid_rgb = rgb;
  assign vi1.capture_req = req1;
  video_capture #(.IMG_W(W), .IMG_H(H), .X_OFS(XO), .Y_OFS(YO), .CONT(0)) u0 (
    .clk(clk), .rst(rst), .vif(vi0));
  video_capture #(.IMG_W(W), .IMG_H(H), .X_OFS(XO), .Y_OFS(YO), .CONT(1)) u1 (
    .clk(clk), .rst(rst), .vif(vi1));

  int errors = 0, checks = 0, cyc = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_data(logic [23:0] c);
`ifdef VIDEO_CAPTURE_GRAY_EN
    int y;
    y = ((77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) & 32'hFFFF) >> 8;
    return {3{8'(y)}};
`else
    return c;
`endif
  endfunction

  // Model: phase 0 idle, 1 armed, 2 capturing, 3 finished; the write address is
  // derived from the pixel's known frame position, not from counting strobes.
  int          ph[2];
  logic        m_err[2];
  logic        p_vs, pp_vs, p_de, rise, rq;
  logic [23:0] p_rgb;
  int          p_x, p_y, a;
  logic        x_en[2], x_done[2], x_busy[2], x_err[2];
  logic [15:0] x_addr[2];
  logic [23:0] x_data[2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; m_err[i] = 0; x_en[i] = 0; x_done[i] = 0;
        x_busy[i] = 0; x_err[i] = 0; x_addr[i] = 0; x_data[i] = 0;
      end
      p_vs = 0; pp_vs = 0; p_de = 0; p_rgb = 0; p_x = 0; p_y = 0;
    end else begin
      rise = p_vs && !pp_vs;
      for (int i = 0; i < 2; i++) begin
        rq = (i == 0) ? req0 : req1;
        x_en[i] = 0;
        x_done[i] = ph[i] == 3;
        if (ph[i] == 0) begin
          if (rq) begin ph[i] = 1; m_err[i] = 0; end
        end else if (ph[i] == 1) begin
          if (rise) ph[i] = 2;
        end else if (ph[i] == 2) begin
          if (rise) m_err[i] = 1;
          if (p_de && p_x >= XO && p_x < XO + W && p_y >= YO && p_y < YO + H) begin
            a = (p_y - YO) * W + (p_x - XO);
            x_en[i] = 1; x_addr[i] = 16'(a); x_data[i] = exp_data(p_rgb);
            if (a == W * H - 1) ph[i] = 3;
          end
        end else ph[i] = (i == 1) ? 1 : 0;
        x_busy[i] = ph[i] != 0;
        x_err[i] = m_err[i];
      end
      pp_vs = p_vs; p_vs = vs; p_de = de; p_rgb = rgb; p_x = px; p_y = py;
    end
  end

  int          wr_cnt[2], done_cnt[2], last_addr[2];
  int          last7_cyc, done_cyc;
  logic [23:0] cap[2][8];
  logic [15:0] alog0[$], alog1[$];
  task automatic cmp(int i, logic en, logic [15:0] ad, logic [23:0] d, logic dn, logic b, logic e);
    chk($sformatf("u%0d_wr_en", i), 32'(en), 32'(x_en[i]));
    if (en && x_en[i]) begin
      chk($sformatf("u%0d_wr_addr", i), 32'(ad), 32'(x_addr[i]));
      chk($sformatf("u%0d_wr_data", i), 32'(d), 32'(x_data[i]));
    end
    chk($sformatf("u%0d_frame_done", i), 32'(dn), 32'(x_done[i]));
    chk($sformatf("u%0d_busy", i), 32'(b), 32'(x_busy[i]));
    chk($sformatf("u%0d_frame_err", i), 32'(e), 32'(x_err[i]));
    if (en) begin
      wr_cnt[i]++;
      last_addr[i] = int'(ad);
      cap[i][ad[2:0]] = d;
      if (i == 0) alog0.push_back(ad); else alog1.push_back(ad);
      if (i == 0 && ad == 16'd7) last7_cyc = cyc;
    end
    if (dn) begin
      done_cnt[i]++;
      if (i == 0) done_cyc = cyc;
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    cmp(0, vi0.ram_wr_en, vi0.ram_wr_addr, vi0.ram_wr_data, vi0.frame_done, vi0.busy, vi0.frame_err);
    cmp(1, vi1.ram_wr_en, vi1.ram_wr_addr, vi1.ram_wr_data, vi1.frame_done, vi1.busy, vi1.frame_err);
  end

  task automatic cyc1(logic v, logic d, int x, int y);
    vs = v; de = d; px = x; py = y;
    rgb = d ? pix[y][x] : 24'h0;
    @(negedge clk);
  endtask
  task automatic frame(int npix, int req_at);
    repeat (2) cyc1(1, 0, 0, 0);
    repeat (2) cyc1(0, 0, 0, 0);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 6; x++) if (y * 6 + x < npix) begin
        if (y * 6 + x == req_at) req0 = 1;
        cyc1(0, 1, x, y);
        req0 = 0;
      end
      repeat (3) cyc1(0, 0, 0, 0);
    end
  endtask
  task automatic request(int i);
    if (i == 0) req0 = 1; else req1 = 1;
    cyc1(0, 0, 0, 0);
    req0 = 0; req1 = 0;
  endtask
  task automatic fill();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 6; x++)
        pix[y][x] = {8'(16 * y + x), 8'h5A, ~8'(16 * y + x)};
  endtask

  int w0, d0, w1, d1, n0, n1;
  initial begin
    vs = 0; de = 0; rgb = 0; px = 0; py = 0; req0 = 0; req1 = 0;
    fill();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", 32'(vi0.ram_wr_en), 0);
    chk("rst_addr", 32'(vi0.ram_wr_addr), 0);
    chk("rst_data", 32'(vi0.ram_wr_data), 0);
    chk("rst_busy", 32'(vi0.busy), 0);
    chk("rst_done", 32'(vi0.frame_done), 0);
    chk("rst_err", 32'(vi0.frame_err), 0);
    rst = 0;
    @(negedge clk);
    // no request: a whole frame must leave the buffer untouched
    w0 = wr_cnt[0];
    frame(18, -1);
    chk("noreq_writes", 32'(wr_cnt[0] - w0), 0);
    // single capture of the 4x2 window at (1,1)
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    request(0);
    chk("armed_busy", 32'(vi0.busy), 1);
    frame(18, -1);
    repeat (4) cyc1(0, 0, 0, 0);
    chk("cap_writes", 32'(wr_cnt[0] - w0), 8);
    chk("cap_last_addr", 32'(last_addr[0]), 7);
    chk("cap_done_cnt", 32'(done_cnt[0] - d0), 1);
    chk("cap_done_lag", 32'(done_cyc - last7_cyc), 1);
    chk("cap_busy_after", 32'(vi0.busy), 0);
`ifdef VIDEO_CAPTURE_GRAY_EN
    chk("cap_data0", 32'(cap[0][0]), 32'h545454);
    chk("cap_data7", 32'(cap[0][7]), 32'h585858);
`else
    chk("cap_data0", 32'(cap[0][0]), 32'h115AEE);
    chk("cap_data7", 32'(cap[0][7]), 32'h245ADB);
`endif
    // primary-colour pixels
    pix[1][1] = 24'hFF0000;
    pix[1][2] = 24'hFFFFFF;
    request(0);
    frame(18, -1);
    repeat (4) cyc1(0, 0, 0, 0);
`ifdef VIDEO_CAPTURE_GRAY_EN
    chk("red_data", 32'(cap[0][0]), 32'h4C4C4C);
`else
    chk("red_data", 32'(cap[0][0]), 32'hFF0000);
`endif
    chk("white_data", 32'(cap[0][1]), 32'hFFFFFF);
    fill();
    // frame restarted after three writes
    w0 = wr_cnt[0]; d0 = done_cnt[0]; n0 = alog0.size();
    request(0);
    frame(10, -1);
    frame(18, -1);
    repeat (4) cyc1(0, 0, 0, 0);
    chk("abort_err", 32'(vi0.frame_err), 1);
    chk("abort_writes", 32'(wr_cnt[0] - w0), 11);
    chk("abort_restart_addr", 32'(alog0[n0 + 3]), 0);
    chk("abort_done_cnt", 32'(done_cnt[0] - d0), 1);
    // request while capturing is ignored; accepted request clears the error
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    request(0);
    chk("req_clears_err", 32'(vi0.frame_err), 0);
    frame(18, 8);
    repeat (4) cyc1(0, 0, 0, 0);
    chk("midreq_writes", 32'(wr_cnt[0] - w0), 8);
    chk("midreq_done_cnt", 32'(done_cnt[0] - d0), 1);
    chk("midreq_err", 32'(vi0.frame_err), 0);
    // continuous instance over three frames
    w1 = wr_cnt[1]; d1 = done_cnt[1]; n1 = alog1.size(); w0 = wr_cnt[0];
    request(1);
    repeat (3) frame(18, -1);
    repeat (4) cyc1(0, 0, 0, 0);
    chk("cont_done_cnt", 32'(done_cnt[1] - d1), 3);
    chk("cont_writes", 32'(wr_cnt[1] - w1), 24);
    chk("cont_addr_f2", 32'(alog1[n1 + 8]), 0);
    chk("cont_addr_f3", 32'(alog1[n1 + 16]), 0);
    chk("cont_busy", 32'(vi1.busy), 1);
    chk("single_idle_writes", 32'(wr_cnt[0] - w0), 0);
    // asynchronous reset in the middle of a capture
    request(0);
    frame(9, -1);
    chk("pre_rst_busy", 32'(vi0.busy), 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_wr_en", 32'(vi0.ram_wr_en), 0);
    chk("mid_rst_addr", 32'(vi0.ram_wr_addr), 0);
    chk("mid_rst_data", 32'(vi0.ram_wr_data), 0);
    chk("mid_rst_busy", 32'(vi0.busy), 0);
    chk("mid_rst_done", 32'(vi0.frame_done), 0);
    chk("mid_rst_err", 32'(vi0.frame_err), 0);
    chk("mid_rst_cont_busy", 32'(vi1.busy), 0);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    w0 = wr_cnt[0]; w1 = wr_cnt[1];
    frame(18, -1);
    chk("post_rst_writes", 32'(wr_cnt[0] - w0), 0);
    chk("post_rst_cont_writes", 32'(wr_cnt[1] - w1), 0);
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    request(0);
    frame(18, -1);
    repeat (4) cyc1(0, 0, 0, 0);
    chk("post_rst_recapture", 32'(wr_cnt[0] - w0), 8);
    chk("post_rst_done", 32'(done_cnt[0] - d0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
